// File: rtl/uart_echo_checker.sv
// Host-side UART echo checker: sends NUM_CHARS 8N1 characters and verifies each echoed byte.
// Reports done/pass/timeout plus mismatch and receive counts, all registered.
module uart_echo_checker #(
  parameter int         CLOCK_FREQ     = 50_000_000,
  parameter int         BAUD_RATE      = 1_000_000,
  parameter logic [7:0] CHAR0          = 8'h61,
  parameter int         NUM_CHARS      = 10,
  parameter int         GAP_CYCLES     = 100,
  parameter int         TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       serial_in,
  output logic       serial_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [7:0] mismatches,
  output logic [7:0] recv_count
);

  localparam int          S         = CLOCK_FREQ / BAUD_RATE;
  localparam logic [31:0] BIT_LAST  = 32'(S - 1);
  localparam logic [31:0] HALF_LAST = 32'(S / 2 - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  NUM8      = 8'(NUM_CHARS);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_GAP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t   tx_state, tx_next;
  rx_state_t   rx_state, rx_next;
  logic [31:0] tx_cnt, rx_cnt, to_cnt;
  logic [2:0]  tx_idx, rx_idx;
  logic [7:0]  tx_sent, tx_char, rx_shift, exp_char;
  logic        tx_done, rx_meta, rx_sync;
  logic        accept, complete, expire;
  logic        tx_bit_end, tx_gap_end, rx_bit_end, rx_half, rx_frame_end, rx_bad;

  assign accept       = start & ~busy;
  assign complete     = busy & tx_done & (recv_count == NUM8);
  // completion has priority over an expiring timeout in the same cycle
  assign expire       = busy & ~complete & (to_cnt == TO_LAST);
  assign tx_bit_end   = (tx_cnt == BIT_LAST);
  assign tx_gap_end   = (tx_cnt == GAP_LAST);
  assign rx_bit_end   = (rx_cnt == BIT_LAST);
  assign rx_half      = (rx_cnt == HALF_LAST);
  assign tx_char      = CHAR0 + tx_sent;
  assign exp_char     = CHAR0 + recv_count;
  assign rx_frame_end = (rx_state == RX_STOP) && rx_bit_end;
  assign rx_bad       = (rx_shift != exp_char) || !rx_sync;

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (accept) tx_next = TX_START;
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_bit_end) tx_next = TX_GAP;
      TX_GAP:   if (tx_gap_end) tx_next = (tx_sent < NUM8) ? TX_START : TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
    if (expire) tx_next = TX_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_state <= TX_IDLE;
    else      tx_state <= tx_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt     <= '0;
      tx_idx     <= '0;
      tx_sent    <= '0;
      tx_done    <= 1'b0;
      serial_out <= 1'b1;
    end else begin
      if (tx_next != tx_state || (tx_state == TX_DATA && tx_bit_end)) tx_cnt <= '0;
      else if (tx_state != TX_IDLE)                                   tx_cnt <= tx_cnt + 32'd1;
      if (tx_state != TX_DATA) tx_idx <= '0;
      else if (tx_bit_end)     tx_idx <= tx_idx + 3'd1;
      if (accept) begin
        tx_sent <= '0;
        tx_done <= 1'b0;
      end else if (!expire) begin
        if (tx_state == TX_STOP && tx_bit_end) tx_sent <= tx_sent + 8'd1;
        if (tx_state == TX_GAP && tx_gap_end && tx_sent >= NUM8) tx_done <= 1'b1;
      end
      case (tx_state)
        TX_START: serial_out <= 1'b0;
        TX_DATA:  serial_out <= tx_char[tx_idx];
        default:  serial_out <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx_sync <= rx_meta;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_sync && recv_count < NUM8) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_end && rx_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_bit_end) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
    if (!busy || expire) rx_next = RX_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_next != rx_state || (rx_state == RX_DATA && rx_bit_end)) rx_cnt <= '0;
      else if (rx_state != RX_IDLE)                                   rx_cnt <= rx_cnt + 32'd1;
      if (rx_state != RX_DATA) begin
        rx_idx <= '0;
      end else if (rx_bit_end) begin
        rx_idx   <= rx_idx + 3'd1;
        rx_shift <= {rx_sync, rx_shift[7:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      mismatches <= '0;
      recv_count <= '0;
      to_cnt     <= '0;
    end else if (accept) begin
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      mismatches <= '0;
      recv_count <= '0;
      to_cnt     <= '0;
    end else if (busy) begin
      to_cnt <= to_cnt + 32'd1;
      if (complete) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (mismatches == 8'd0);
      end else if (expire) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        timeout <= 1'b1;
        pass    <= 1'b0;
      end else if (rx_frame_end) begin
        recv_count <= recv_count + 8'd1;
        if (rx_bad && mismatches != 8'hFF) mismatches <= mismatches + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_checker.sv
// Loopback bench for uart_echo_checker: the echo line is the TX line with optional bit flips and glitches.
// Expected results come from frame/bit timing arithmetic and per-frame corruption masks.
module tb_uart_echo_checker;

  localparam int S    = 16;
  localparam int GAP  = 30;
  localparam int NUM  = 10;
  localparam int TO   = 4000;
  localparam int F    = 10 * S + GAP;
  localparam int RUN  = NUM * F;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       tie_high = 1'b0;
  logic       serial_in, serial_out, busy, done, pass, timeout;
  logic [7:0] mismatches, recv_count;

  logic       inv = 1'b0;
  logic       glitch = 1'b0;
  int         cyc = 0;
  int         t0 = 0;
  bit         armed = 1'b0;
  int         g_lo = -1;
  int         g_hi = -1;
  logic [9:0] mask [NUM];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  assign serial_in = tie_high ? 1'b1 : ((serial_out ^ inv) & ~glitch);

  uart_echo_checker #(
    .CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .CHAR0(8'hFB),
    .NUM_CHARS(NUM), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .serial_in(serial_in),
    .serial_out(serial_out), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .mismatches(mismatches), .recv_count(recv_count)
  );

  // r = cycles since the accepting edge; frame f bit b occupies [1+f*F+b*S, 1+f*F+(b+1)*S)
  function automatic logic flip_at(input int r);
    int f, off;
    if (!armed || r < 1) return 1'b0;
    f   = (r - 1) / F;
    off = (r - 1) % F;
    if (f >= NUM || off >= 10 * S) return 1'b0;
    return mask[f][off / S];
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    inv    <= flip_at(cyc + 1 - t0);
    glitch <= armed && (cyc + 1 - t0 >= g_lo) && (cyc + 1 - t0 < g_hi);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_masks();
    for (int f = 0; f < NUM; f++) mask[f] = '0;
    g_lo = -1;
    g_hi = -1;
  endtask

  task automatic run_start();
    @(negedge clk);
    armed = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
    armed = 1'b1;
  endtask

  task automatic wait_done(input int limit, output int rel);
    rel = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        rel = cyc - t0;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input int exp_mism, input bit poke);
    int rel;
    run_start();
    check({tag, "_accept_busy"}, busy, 1);
    check({tag, "_accept_done_clr"}, done, 0);
    if (poke) begin
      repeat (400) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_after_poke"}, busy, 1);
    end
    wait_done(RUN + 200, rel);
    check({tag, "_done_seen"}, (rel >= 0), 1);
    check({tag, "_done_latency"}, (rel >= RUN && rel <= RUN + 60), 1);
    check({tag, "_pass"}, pass, (exp_mism == 0));
    check({tag, "_mismatches"}, mismatches, 32'(exp_mism));
    check({tag, "_recv_count"}, recv_count, NUM);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int rel, exp_m, fg;
    clear_masks();
    repeat (3) @(negedge clk);
    check("rst_serial_out", serial_out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_timeout", timeout, 0);
    check("rst_mismatches", mismatches, 0);
    check("rst_recv_count", recv_count, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_and_check("clean", 0, 1'b1);
    repeat (50) @(negedge clk);
    check("clean_done_held", done, 1);
    check("clean_pass_held", pass, 1);

    clear_masks();
    mask[3][1] = 1'b1;
    run_and_check("frame3_bit0", 1, 1'b0);

    clear_masks();
    mask[7][9] = 1'b1;
    run_and_check("frame7_stop", 1, 1'b0);

    for (int it = 0; it < 3; it++) begin
      clear_masks();
      exp_m = 0;
      for (int f = 0; f < NUM; f++) begin
        if ($urandom_range(0, 2) == 0) begin
          mask[f][$urandom_range(1, 9)] = 1'b1;
          exp_m++;
        end
      end
      run_and_check("random_corrupt", exp_m, 1'b0);
    end

    clear_masks();
    fg   = int'($urandom_range(0, NUM - 2));
    g_lo = fg * F + 161 + int'($urandom_range(0, 3));
    g_hi = g_lo + int'($urandom_range(3, 6));
    run_and_check("glitch", 0, 1'b0);
    g_lo = -1;
    g_hi = -1;

    tie_high = 1'b1;
    run_start();
    wait_done(TO + 100, rel);
    check("to_done_seen", (rel >= 0), 1);
    check("to_latency", (rel >= TO - 2 && rel <= TO + 2), 1);
    check("to_timeout", timeout, 1);
    check("to_pass", pass, 0);
    check("to_recv_count", recv_count, 0);
    check("to_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("to_serial_out", serial_out, 1);
    tie_high = 1'b0;

    clear_masks();
    run_start();
    repeat (2 * F + 1 + 4 * S) @(negedge clk);
    check("mid_recv_count", recv_count, 2);
    check("mid_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_serial_out", serial_out, 1);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_recv_count", recv_count, 0);
    check("arst_mismatches", mismatches, 0);
    repeat (3) @(negedge clk);
    armed = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", busy, 0);
    run_and_check("after_reset", 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_echo_checker.md
# uart_echo_checker

Synthesizable host-side end of the CPU's UART echo link. It transmits a fixed sequence of 8N1 characters into the CPU's `serial_in` and receives the echoed characters from the CPU's `serial_out`. Each echoed character is compared against the one sent, and the block reports done, pass, timeout and a mismatch count. It sits outside the `cpu` instance, either on-board for hardware bring-up or in a top-level bench in place of behavioural serial tasks.

## Interface
- `CLOCK_FREQ`, 50_000_000, clock frequency in Hz.
- `BAUD_RATE`, 1_000_000, line rate; S = `CLOCK_FREQ`/`BAUD_RATE` cycles per bit (default 50, must be ≥ 4).
- `CHAR0`, 8'h61, first character; character k is `CHAR0`+k, modulo 256.
- `NUM_CHARS`, 10, characters per run, range 1..255.
- `GAP_CYCLES`, 100, idle cycles held high after each transmitted stop bit.
- `TIMEOUT_CYCLES`, 100_000, run limit counted from start.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  one-cycle run request.
- `serial_in`  in  1  echoed line from CPU `serial_out`; asynchronous, idles high.
- `serial_out`  out  1  line to CPU `serial_in`; idles high.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until the next start.
- `pass`  out  1  valid while `done`; 1 iff all characters received, none mismatched, no timeout.
- `timeout`  out  1  run ended by the timeout limit.
- `mismatches`  out  8  count of bad characters; saturates at 255.
- `recv_count`  out  8  characters received this run.

## Operation
- Reset values: `serial_out`=1, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `mismatches`=0, `recv_count`=0. Both FSMs go to IDLE and all counters clear.
- Accepting `start`:
  - `start` is accepted when `busy`=0; it is ignored while `busy`=1.
  - Acceptance clears `done`, `pass`, `timeout`, `mismatches`, `recv_count` and the timeout counter, then sets `busy`.
- TX FSM (IDLE → START → DATA → STOP → GAP):
  - Each of START, DATA and STOP holds its bit for exactly S cycles. START drives 0, DATA sends 8 bits LSB first, STOP drives 1.
  - GAP holds 1 for `GAP_CYCLES` cycles.
  - After GAP, the FSM returns to START while sent < `NUM_CHARS`; otherwise it goes to IDLE with tx_done set.
- RX FSM (IDLE → START → DATA → STOP):
  - `serial_in` passes through a 2-flop synchronizer.
  - IDLE waits for a synchronized 0. START waits S/2 cycles and re-samples: 0 → DATA, 1 → IDLE (glitch rejected, nothing counted).
  - DATA takes 8 samples at S intervals, LSB first. STOP samples once after a further S, then returns to IDLE.
  - RX runs only while `busy`=1; line activity while idle or done is ignored.
- Checking:
  - At STOP, the received byte is compared with `CHAR0`+`recv_count` (8-bit).
  - The character is bad if the byte differs or the stop bit is 0; a bad character increments `mismatches`.
  - `recv_count` increments on every completed frame, good or bad.
- Completion:
  - The run finishes when tx_done is set and `recv_count`=`NUM_CHARS`. `busy` drops, `done` rises, and `pass` = (`mismatches`==0).
- Timeout:
  - The timeout counter runs while `busy`=1. On reaching `TIMEOUT_CYCLES` without completion: `done`=1, `timeout`=1, `pass`=0, `busy`=0.
  - Both FSMs abort to IDLE; `serial_out` returns to 1 the next cycle.
  - Completion and timeout in the same cycle: completion wins.
- Extra frames after `recv_count` reaches `NUM_CHARS` but before tx_done are ignored; no count and no compare.

## Timing
- `serial_out` falls on the first rising edge after the edge that accepts `start`.
- One frame is 10·S cycles; frame starts are spaced 10·S + `GAP_CYCLES` cycles apart.
- RX sample points are t0 + S/2 + k·S for k = 0 (start), 1..8 (data) and 9 (stop). t0 is the first cycle the synchronized input reads 0, which is 2 cycles after the pin falls.
- `mismatches` and `recv_count` update 1 cycle after the stop sample.
- `done` rises 1 cycle after the completing update.
- All outputs are registered.
- `rst` low mid-frame forces `serial_out`=1 and clears all outputs asynchronously. No `start` is retained across reset.

## Test plan
- Loopback with `serial_out` wired to `serial_in`, default parameters, pulse `start` → `done`=1, `pass`=1, `mismatches`=0, `recv_count`=10, `timeout`=0. `done` rises within 10·(500+100)+60 cycles of `start`.
- Loopback with bit 0 of the 4th frame inverted (0x64 echoed as 0x65) → `pass`=0, `mismatches`=1, `recv_count`=10.
- `serial_in` tied high → `done`=1 and `timeout`=1 exactly `TIMEOUT_CYCLES` after start (±2 cycles); `pass`=0, `recv_count`=0, `serial_out`=1 afterwards.
- 20-cycle low glitch on `serial_in` during a loopback run → glitch ignored, final `recv_count`=10, `pass`=1.
- Loopback with the stop bit of frame 7 forced to 0 → `mismatches`=1, `pass`=0.
- `rst` low in the middle of the data bits of frame 2 → `serial_out`=1 and all outputs 0 immediately. After release, a new `start` gives a clean pass.
